// File: rtl/addsub_rr_sched.sv
// Round-robin scheduler sharing one add/subtract unit between N_REQ requesters.
// The result is registered and returned on a single valid/ready port, tagged with the owner ID.
module addsub_rr_sched #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W     = 4,
  parameter int unsigned IDW   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*W-1:0]   req_a,
  input  logic [N_REQ*W-1:0]   req_b,
  input  logic [N_REQ-1:0]     req_sub,
  input  logic [N_REQ-1:0]     req_signed,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [W-1:0]         res_data,
  output logic                 res_ovf,
  output logic [IDW-1:0]       res_id
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [W-1:0]   res_data_q, res_data_d;
  logic           res_ovf_q, res_ovf_d;
  logic [IDW-1:0] res_id_q, res_id_d;

  logic           acc_en_c;
  logic           gnt_found_c;
  logic           gnt_c;
  logic [IDW-1:0] gnt_idx_c;
  logic [IDW-1:0] cand_c;
  logic [W-1:0]   op_a_c, op_b_c;
  logic           op_sub_c, op_signed_c;
  logic [W:0]     sum_c;
  logic           ovf_c;

  // Rotating priority search starting at the pointer; gated off while in reset.
  always_comb begin
    acc_en_c    = rst_n & ((state_q == ST_IDLE) | res_ready);
    gnt_found_c = 1'b0;
    gnt_idx_c   = '0;
    cand_c      = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand_c = IDW'((32'(ptr_q) + k) % N_REQ);
      if (!gnt_found_c && req_valid[cand_c]) begin
        gnt_found_c = 1'b1;
        gnt_idx_c   = cand_c;
      end
    end
    gnt_c = acc_en_c & gnt_found_c;
    req_ready = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      req_ready[i] = gnt_c && (gnt_idx_c == IDW'(i));
    end
  end

  // Operand mux and shared arithmetic unit.
  always_comb begin
    op_a_c      = '0;
    op_b_c      = '0;
    op_sub_c    = 1'b0;
    op_signed_c = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt_idx_c == IDW'(i)) begin
        op_a_c      = req_a[i*W +: W];
        op_b_c      = req_b[i*W +: W];
        op_sub_c    = req_sub[i];
        op_signed_c = req_signed[i];
      end
    end
    if (op_sub_c) begin
      sum_c = {1'b0, op_a_c} - {1'b0, op_b_c};
    end else begin
      sum_c = {1'b0, op_a_c} + {1'b0, op_b_c};
    end
    // Bit W is the carry for unsigned add and the borrow for unsigned sub.
    if (op_signed_c) begin
      if (op_sub_c) begin
        ovf_c = (op_a_c[W-1] != op_b_c[W-1]) && (sum_c[W-1] != op_a_c[W-1]);
      end else begin
        ovf_c = (op_a_c[W-1] == op_b_c[W-1]) && (sum_c[W-1] != op_a_c[W-1]);
      end
    end else begin
      ovf_c = sum_c[W];
    end
  end

  // Next-state logic: a grant always loads a new result; otherwise drain on res_ready.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    res_data_d = res_data_q;
    res_ovf_d  = res_ovf_q;
    res_id_d   = res_id_q;
    if (gnt_c) begin
      state_d    = ST_BUSY;
      ptr_d      = IDW'((32'(gnt_idx_c) + 32'd1) % N_REQ);
      res_data_d = sum_c[W-1:0];
      res_ovf_d  = ovf_c;
      res_id_d   = gnt_idx_c;
    end else if ((state_q == ST_BUSY) && res_ready) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      res_data_q <= '0;
      res_ovf_q  <= 1'b0;
      res_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      res_data_q <= res_data_d;
      res_ovf_q  <= res_ovf_d;
      res_id_q   <= res_id_d;
    end
  end

  assign res_valid = (state_q == ST_BUSY);
  assign res_data  = res_data_q;
  assign res_ovf   = res_ovf_q;
  assign res_id    = res_id_q;

endmodule

// File: tb/tb_addsub_rr_sched.sv
// Self-checking bench for addsub_rr_sched: reference arbiter model plus a result scoreboard.
module tb_addsub_rr_sched;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned W     = 4;
  localparam int unsigned IDW   = 2;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic           ovf;
    logic [W-1:0]   data;
  } res_t;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N_REQ-1:0]     req_valid;
  logic [N_REQ-1:0]     req_ready;
  logic [N_REQ*W-1:0]   req_a;
  logic [N_REQ*W-1:0]   req_b;
  logic [N_REQ-1:0]     req_sub;
  logic [N_REQ-1:0]     req_signed;
  logic                 res_valid;
  logic                 res_ready;
  logic [W-1:0]         res_data;
  logic                 res_ovf;
  logic [IDW-1:0]       res_id;

  int   n_checks = 0;
  int   n_errors = 0;
  res_t sb[$];
  logic m_busy;
  int   m_ptr;
  int   last_gnt;
  logic keep_valid;

  addsub_rr_sched #(.N_REQ(N_REQ), .W(W), .IDW(IDW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_sub    (req_sub),
    .req_signed (req_signed),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_ovf    (res_ovf),
    .res_id     (res_id)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference arithmetic in integer range terms, independent of bit tricks.
  function automatic res_t model(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sub, input logic sgn);
    res_t m;
    int r, lo, hi;
    if (sgn) begin
      r  = sub ? (int'($signed(a)) - int'($signed(b))) : (int'($signed(a)) + int'($signed(b)));
      lo = -(1 << (W-1));
      hi = (1 << (W-1)) - 1;
    end else begin
      r  = sub ? (int'(a) - int'(b)) : (int'(a) + int'(b));
      lo = 0;
      hi = (1 << W) - 1;
    end
    m.id   = IDW'(id);
    m.ovf  = (r < lo) || (r > hi);
    m.data = W'(r);
    return m;
  endfunction

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, input logic sgn);
    req_a[i*W +: W]  = a;
    req_b[i*W +: W]  = b;
    req_sub[i]       = sub;
    req_signed[i]    = sgn;
    req_valid[i]     = 1'b1;
  endtask

  // One clock cycle: check outputs against the model, then advance the model across the edge.
  task automatic step();
    logic [N_REQ-1:0] exp_rdy;
    logic acc;
    int g, idx;
    #2;
    check("res_valid", 32'(res_valid), 32'(m_busy));
    if (m_busy) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        check("res_data", 32'(res_data), 32'(sb[0].data));
        check("res_ovf",  32'(res_ovf),  32'(sb[0].ovf));
        check("res_id",   32'(res_id),   32'(sb[0].id));
      end
    end
    acc     = !m_busy || res_ready;
    g       = -1;
    exp_rdy = '0;
    if (acc) begin
      for (int k = 0; k < int'(N_REQ); k++) begin
        idx = (m_ptr + k) % int'(N_REQ);
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (m_busy && res_ready && sb.size() > 0) void'(sb.pop_front());
    if (g >= 0) begin
      sb.push_back(model(g, req_a[g*W +: W], req_b[g*W +: W], req_sub[g], req_signed[g]));
      m_ptr    = (g + 1) % int'(N_REQ);
      m_busy   = 1'b1;
      last_gnt = g;
    end else begin
      last_gnt = -1;
      if (res_ready) m_busy = 1'b0;
    end
    @(posedge clk);
    #1;
    if (g >= 0) begin
      if (keep_valid) begin
        req_a[g*W +: W] = W'($urandom);
        req_b[g*W +: W] = W'($urandom);
        req_sub[g]      = 1'($urandom);
        req_signed[g]   = 1'($urandom);
      end else begin
        req_valid[g] = 1'b0;
      end
    end
  endtask

  initial begin
    int exp_gnt[5];
    logic [W-1:0] held_data;
    logic [IDW-1:0] held_id;
    exp_gnt = '{0, 1, 2, 3, 0};

    rst_n      = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_sub    = '0;
    req_signed = '0;
    res_ready  = 1'b0;
    keep_valid = 1'b0;
    m_busy     = 1'b0;
    m_ptr      = 0;
    last_gnt   = -1;
    #3;
    req_valid = 4'b1111;
    #1;
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data",  32'(res_data),  32'd0);
    check("rst_res_ovf",   32'(res_ovf),   32'd0);
    check("rst_res_id",    32'(res_id),    32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    res_ready = 1'b1;
    step();

    // Signed subtract 1-1
    set_req(0, 4'd1, 4'd1, 1'b1, 1'b1);
    step();
    check("t1_data", 32'(res_data), 32'd0);
    check("t1_ovf",  32'(res_ovf),  32'd0);
    check("t1_id",   32'(res_id),   32'd0);
    step();

    // Signed add overflow 7+1
    set_req(1, 4'd7, 4'd1, 1'b0, 1'b1);
    step();
    check("t2_data", 32'(res_data), 32'b1000);
    check("t2_ovf",  32'(res_ovf),  32'd1);
    check("t2_id",   32'(res_id),   32'd1);
    step();

    // Unsigned subtracts
    set_req(2, 4'd7, 4'd5, 1'b1, 1'b0);
    step();
    check("t3a_data", 32'(res_data), 32'd2);
    check("t3a_ovf",  32'(res_ovf),  32'd0);
    set_req(3, 4'd5, 4'd7, 1'b1, 1'b0);
    step();
    check("t3b_data", 32'(res_data), 32'd14);
    check("t3b_ovf",  32'(res_ovf),  32'd1);
    step();
    step();

    // Fairness: all requesters continuously valid
    keep_valid = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    for (int c = 0; c < 5; c++) begin
      step();
      check("t4_grant", 32'(last_gnt), 32'(exp_gnt[c]));
    end
    keep_valid = 1'b0;
    req_valid  = '0;
    step();
    step();

    // Backpressure: result pending, res_ready low, another request waiting
    set_req(2, 4'd9, 4'd3, 1'b0, 1'b0);
    step();
    held_data = res_data;
    held_id   = res_id;
    res_ready = 1'b0;
    set_req(0, 4'd4, 4'd6, 1'b1, 1'b1);
    for (int c = 0; c < 5; c++) begin
      step();
      check("t5_stall_ready", 32'(req_ready), 32'd0);
      check("t5_hold_data",   32'(res_data),  32'(held_data));
      check("t5_hold_id",     32'(res_id),    32'(held_id));
    end
    res_ready = 1'b1;
    #2;
    check("t5_resume_ready", 32'(req_ready), 32'b0001);
    step();
    step();
    step();

    // Random traffic with occasional backpressure and withdrawals
    for (int c = 0; c < 60; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        int i;
        i = $urandom_range(0, 3);
        if (!req_valid[i]) set_req(i, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      end
      if ($urandom_range(0, 9) == 0) req_valid[$urandom_range(0, 3)] = 1'b0;
      res_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    req_valid = '0;
    res_ready = 1'b1;
    step();
    step();

    // Reset while busy
    res_ready = 1'b0;
    set_req(1, 4'd3, 4'd2, 1'b0, 1'b0);
    step();
    check("t6_busy", 32'(res_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(res_valid), 32'd0);
    req_valid = 4'b0100;
    set_req(2, 4'd2, 4'd3, 1'b1, 1'b1);
    #1;
    check("t6_rst_ready", 32'(req_ready), 32'd0);
    sb.delete();
    m_busy = 1'b0;
    m_ptr  = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    res_ready = 1'b1;
    #2;
    check("t6_first_grant", 32'(req_ready), 32'b0100);
    step();
    check("t6_id",   32'(res_id),   32'd2);
    check("t6_data", 32'(res_data), 32'd15);
    check("t6_ovf",  32'(res_ovf),  32'd0);
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
